// File: rtl/des_sched_pkg.sv
// Shared types and constants for the DES job scheduler.
package des_sched_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        BUSY  = 2'd3
    } sched_state_e;

    localparam logic MODE_ENCRYPT = 1'b0;
    localparam logic MODE_DECRYPT = 1'b1;

    localparam int DES_ROUNDS  = 16;
    localparam int DES_LATENCY = 16;

endpackage

// File: rtl/des_rr_arbiter_2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module des_rr_arbiter_2 (
    input  logic [1:0] eligible,
    input  logic       last,
    output logic [1:0] grant
);

    assign grant[0] = eligible[0] & (~eligible[1] | last);
    assign grant[1] = eligible[1] & (~eligible[0] | ~last);

endmodule

// File: rtl/des_job_scheduler.sv
// Shares one iterative DES engine between two requesters with per-requester result buffers.
// Optional BUSY watchdog with engine abort: define DES_SCHED_TIMEOUT_EN.
module des_job_scheduler
    import des_sched_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_mode,
    input  logic [DATA_W-1:0] req0_data,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_mode,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,
    output logic              eng_enable,
    output logic              eng_start,
    output logic              eng_mode,
    output logic [DATA_W-1:0] eng_data_in,
    input  logic [DATA_W-1:0] eng_data_out,
    input  logic              eng_out_valid,
    output logic              eng_abort
);

    sched_state_e      state, state_nxt;
    logic              owner;
    logic              rr_last;
    logic [1:0]        req_valid, rsp_ready, eligible, grant;
    logic [1:0]        rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q [2];
    logic              done, tmo, abort;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_tmo_range
        $error("TIMEOUT_CYC must fit the 8-bit busy counter");
    end

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    // A requester whose result is still unread is not served again.
    assign eligible  = req_valid & ~rsp_valid_q;

    des_rr_arbiter_2 u_arb (
        .eligible (eligible),
        .last     (rr_last),
        .grant    (grant)
    );

    assign req0_ready = (state == IDLE) & grant[0];
    assign req1_ready = (state == IDLE) & grant[1];
    assign eng_start  = (state == ISSUE);
    assign done       = (state == BUSY) & eng_out_valid;

`ifdef DES_SCHED_TIMEOUT_EN
    logic [7:0] busy_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              busy_cnt <= '0;
        else if (state != BUSY)  busy_cnt <= '0;
        else                     busy_cnt <= busy_cnt + 8'd1;
    end

    // A result arriving on the final cycle still wins over the abort.
    assign tmo       = (state == BUSY) & (busy_cnt == 8'(TIMEOUT_CYC - 1));
    assign abort     = tmo & ~eng_out_valid;
    assign eng_abort = tmo;
`else
    assign tmo       = 1'b0;
    assign abort     = 1'b0;
    assign eng_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = IDLE;
            IDLE:    if (|grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY: begin
                if (done)       state_nxt = IDLE;
                else if (abort) state_nxt = INIT;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner       <= 1'b0;
            rr_last     <= 1'b1;
            eng_mode    <= MODE_ENCRYPT;
            eng_data_in <= '0;
            eng_enable  <= 1'b0;
        end else begin
            eng_enable <= 1'b1;
            if (state == IDLE && |grant) begin
                owner       <= grant[1];
                eng_mode    <= grant[1] ? req1_mode : req0_mode;
                eng_data_in <= grant[1] ? req1_data : req0_data;
            end
            if (done || abort) rr_last <= owner;
        end
    end

    for (genvar n = 0; n < 2; n++) begin : g_rsp
        logic              v_q, e_q, hit;
        logic [DATA_W-1:0] d_q;

        assign hit = (owner == 1'(n));

        // Capture and drain never collide: an owner is granted only with an empty buffer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                e_q <= 1'b0;
                d_q <= '0;
            end else if (done && hit) begin
                v_q <= 1'b1;
                e_q <= 1'b0;
                d_q <= eng_data_out;
            end else if (abort && hit) begin
                v_q <= 1'b1;
                e_q <= 1'b1;
                d_q <= '0;
            end else if (v_q && rsp_ready[n]) begin
                v_q <= 1'b0;
                e_q <= 1'b0;
            end
        end

        assign rsp_valid_q[n] = v_q;
        assign rsp_err_q[n]   = e_q;
        assign rsp_data_q[n]  = d_q;
    end

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp0_err   = rsp_err_q[0];
    assign rsp0_data  = rsp_data_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp1_err   = rsp_err_q[1];
    assign rsp1_data  = rsp_data_q[1];

endmodule

// File: tb/tb_des_job_scheduler.sv
// Bench for des_job_scheduler: stub DES engine plus a per-requester job scoreboard.
module tb_des_job_scheduler;

    localparam int          DW  = 128;
    localparam int          TMO = 24;
    localparam logic [63:0] K   = 64'h133457799BBCDFF1;
    localparam logic [63:0] P   = 64'h0123456789ABCDEF;
    localparam logic [63:0] C   = 64'h85E813540F0AB405;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_mode, rsp0_valid, rsp0_ready, rsp0_err;
    logic          req1_valid, req1_ready, req1_mode, rsp1_valid, rsp1_ready, rsp1_err;
    logic [DW-1:0] req0_data, rsp0_data, req1_data, rsp1_data;
    logic          eng_enable, eng_start, eng_mode, eng_out_valid, eng_abort;
    logic [DW-1:0] eng_data_in, eng_data_out;

    always #5 clk = ~clk;

    des_job_scheduler #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode), .req0_data(req0_data),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode), .req1_data(req1_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .eng_enable(eng_enable), .eng_start(eng_start), .eng_mode(eng_mode), .eng_data_in(eng_data_in),
        .eng_data_out(eng_data_out), .eng_out_valid(eng_out_valid), .eng_abort(eng_abort)
    );

    // Engine stand-in: known DES vectors, otherwise a cheap keyed scramble.
    function automatic logic [DW-1:0] eng_f(input logic m, input logic [DW-1:0] d);
        if (!m && d == {K, P}) return {K, C};
        if (m && d == {K, C})  return {K, P};
        return {d[127:64], {d[31:0], d[63:32]} ^ d[127:64] ^ {64{m}}};
    endfunction

    logic          run, jm;
    int            ecnt;
    logic [DW-1:0] jd;
    bit            hang;

    // Strobes out_valid 15 cycles after the start pulse (accept T, start T+1, result T+16).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0; ecnt <= 0; eng_out_valid <= 1'b0; eng_data_out <= '0; jd <= '0; jm <= 1'b0;
        end else begin
            eng_out_valid <= 1'b0;
            if (eng_start) begin
                run <= 1'b1; ecnt <= 0; jd <= eng_data_in; jm <= eng_mode;
            end else if (eng_abort) begin
                run <= 1'b0;
            end else if (run) begin
                ecnt <= ecnt + 1;
                if (ecnt == 13) begin
                    run <= 1'b0;
                    if (!hang) begin
                        eng_out_valid <= 1'b1;
                        eng_data_out  <= eng_f(jm, jd);
                    end
                end
            end
        end
    end

    int            pass_cnt = 0, total_cnt = 0;
    int            cyc = 0, last_acc, last_grant;
    int            acc_cyc [2];
    logic          pending [2], prev_v [2], prev_take [2], exp_err [2];
    logic [DW-1:0] exp_data [2];
    logic [DW-1:0] last_d;
    logic          last_m;
    int            grants [$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic flush();
        last_acc = -100; last_grant = 1; last_d = '0; last_m = 1'b0;
        for (int n = 0; n < 2; n++) begin
            acc_cyc[n] = 0; pending[n] = 1'b0; prev_v[n] = 1'b0; prev_take[n] = 1'b0;
            exp_err[n] = 1'b0; exp_data[n] = '0;
        end
    endtask

    task automatic step();
        @(posedge clk); #1; cyc++;
    endtask

    function automatic logic [DW-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drive_req(input int n, input logic v, input logic m, input logic [DW-1:0] d);
        if (n == 0) begin req0_valid = v; req0_mode = m; req0_data = d; end
        else        begin req1_valid = v; req1_mode = m; req1_data = d; end
    endtask

    // Scoreboard: one outstanding job per requester, results in grant order, 17-cycle latency.
    task automatic observe();
        logic [1:0]    rdy, qv, rv, rr, re;
        logic [DW-1:0] qd [2], rd [2];
        logic          qm [2];
        #2;
        rdy = {req1_ready, req0_ready}; qv = {req1_valid, req0_valid};
        rv = {rsp1_valid, rsp0_valid};  rr = {rsp1_ready, rsp0_ready}; re = {rsp1_err, rsp0_err};
        qd[0] = req0_data; qd[1] = req1_data; qm[0] = req0_mode; qm[1] = req1_mode;
        rd[0] = rsp0_data; rd[1] = rsp1_data;
        if (eng_start) begin
            check("start_time", 128'(cyc), 128'(last_acc + 1));
            check("start_data", eng_data_in, last_d);
            check("start_mode", 128'(eng_mode), 128'(last_m));
        end
        if (eng_out_valid) check("mode_hold", 128'(eng_mode), 128'(last_m));
        if (eng_abort) begin
            check("abort_time", 128'(cyc), 128'(last_acc + 1 + TMO));
            exp_data[last_grant] = '0;
            exp_err[last_grant]  = 1'b1;
            acc_cyc[last_grant]  = cyc - 16;
        end
        if (|rdy) check("one_grant", 128'($countones(rdy)), 128'(1));
        for (int n = 0; n < 2; n++) begin
            if (rdy[n]) begin
                check("grant_elig", 128'(rv[n]), 128'(0));
                check("grant_spacing", 128'(cyc - last_acc >= 17), 128'(1));
                if (qv == 2'b11 && rv == 2'b00) check("rr_order", 128'(n != last_grant), 128'(1));
                check("overrun", 128'(pending[n]), 128'(0));
                pending[n] = 1'b1; exp_data[n] = eng_f(qm[n], qd[n]); exp_err[n] = 1'b0;
                acc_cyc[n] = cyc; last_acc = cyc; last_grant = n; last_d = qd[n]; last_m = qm[n];
                grants.push_back(n);
            end
            if (prev_take[n]) check("rsp_clear", 128'(rv[n]), 128'(0));
            else if (prev_v[n] && !rv[n]) check("rsp_hold", 128'(rv[n]), 128'(1));
            if (rv[n] && !prev_v[n]) begin
                check("rsp_pending", 128'(pending[n]), 128'(1));
                check("rsp_latency", 128'(cyc - acc_cyc[n]), 128'(17));
            end
            if (rv[n] && rr[n]) begin
                check("rsp_data", rd[n], exp_data[n]);
                check("rsp_err", 128'(re[n]), 128'(exp_err[n]));
                pending[n] = 1'b0;
            end
            prev_v[n] = rv[n]; prev_take[n] = rv[n] & rr[n];
        end
    endtask

    task automatic do_job(input int n, input logic m, input logic [DW-1:0] d,
                          input logic [DW-1:0] expv, input bit take, output int wt);
        bit got;
        wt = -1; got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(); drive_req(n, 1'b1, m, d); observe();
            if ((n == 0) ? req0_ready : req1_ready) begin wt = k; break; end
        end
        check("job_accept", 128'(wt >= 0), 128'(1));
        for (int k = 0; k < 40; k++) begin
            step(); drive_req(n, 1'b0, m, d); observe();
            if ((n == 0) ? rsp0_valid : rsp1_valid) begin got = 1'b1; break; end
        end
        check("job_rsp_seen", 128'(got), 128'(1));
        check("job_rsp_data", (n == 0) ? rsp0_data : rsp1_data, expv);
        if (take) begin
            step(); if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1; observe();
            step(); rsp0_ready = 1'b0; rsp1_ready = 1'b0; observe();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int            wt, gs;
        logic [DW-1:0] d;
        rst_n = 1'b0; hang = 1'b0;
        drive_req(0, 1'b0, 1'b0, '0); drive_req(1, 1'b0, 1'b0, '0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        flush();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp0_valid", 128'(rsp0_valid), 128'(0));
        check("rst_rsp1_valid", 128'(rsp1_valid), 128'(0));
        check("rst_rsp0_err", 128'(rsp0_err), 128'(0));
        check("rst_rsp1_err", 128'(rsp1_err), 128'(0));
        check("rst_rsp0_data", rsp0_data, '0);
        check("rst_rsp1_data", rsp1_data, '0);
        check("rst_eng_start", 128'(eng_start), 128'(0));
        check("rst_eng_mode", 128'(eng_mode), 128'(0));
        check("rst_eng_data", eng_data_in, '0);
        check("rst_eng_abort", 128'(eng_abort), 128'(0));
        check("rst_eng_enable", 128'(eng_enable), 128'(0));

        // Release mid-cycle: that cycle is INIT, the next one is IDLE.
        rst_n = 1'b1; drive_req(0, 1'b1, 1'b0, {K, P}); observe();
        check("init_ready", 128'(req0_ready), 128'(0));
        do_job(0, 1'b0, {K, P}, {K, C}, 1'b1, wt);
        check("init_len", 128'(wt), 128'(0));
        check("enable_up", 128'(eng_enable), 128'(1));
        do_job(1, 1'b1, {K, C}, {K, P}, 1'b1, wt);

        gs = grants.size();
        for (int k = 0; k < 300 && grants.size() < gs + 4; k++) begin
            step();
            drive_req(0, 1'b1, rbit(), rand128()); drive_req(1, 1'b1, rbit(), rand128());
            rsp0_ready = 1'b1; rsp1_ready = 1'b1; observe();
        end
        check("alt_cnt", 128'(grants.size() - gs), 128'(4));
        if (grants.size() >= gs + 4)
            for (int i = 0; i < 4; i++) check("alt_seq", 128'(grants[gs + i]), 128'(i % 2));

        gs = grants.size();
        for (int k = 0; k < 300 && grants.size() < gs + 4; k++) begin
            step();
            drive_req(0, 1'b1, rbit(), rand128()); drive_req(1, 1'b1, rbit(), rand128());
            rsp0_ready = 1'b0; rsp1_ready = 1'b1; observe();
        end
        check("stall_cnt", 128'(grants.size() - gs), 128'(4));
        if (grants.size() >= gs + 4)
            for (int i = 0; i < 4; i++) check("stall_seq", 128'(grants[gs + i]), 128'(i != 0));
        check("stall_hold_v", 128'(rsp0_valid), 128'(1));
        check("stall_hold_d", rsp0_data, exp_data[0]);
        step(); rsp0_ready = 1'b1; observe();
        gs = grants.size();
        for (int k = 0; k < 60 && grants.size() == gs; k++) begin
            step();
            drive_req(0, 1'b1, rbit(), rand128()); drive_req(1, 1'b1, rbit(), rand128());
            rsp0_ready = 1'b0; rsp1_ready = 1'b1; observe();
        end
        check("unstall_cnt", 128'(grants.size() - gs), 128'(1));
        if (grants.size() > gs) check("unstall_grant", 128'(grants[gs]), 128'(0));

        for (int k = 0; k < 400; k++) begin
            step();
            drive_req(0, 1'($urandom_range(0, 3) != 0), rbit(), rand128());
            drive_req(1, 1'($urandom_range(0, 3) != 0), rbit(), rand128());
            rsp0_ready = rbit(); rsp1_ready = rbit(); observe();
        end
        for (int k = 0; k < 40; k++) begin
            step();
            drive_req(0, 1'b0, 1'b0, '0); drive_req(1, 1'b0, 1'b0, '0);
            rsp0_ready = 1'b1; rsp1_ready = 1'b1; observe();
        end
        check("drain_pending0", 128'(pending[0]), 128'(0));
        check("drain_pending1", 128'(pending[1]), 128'(0));
        step(); rsp0_ready = 1'b0; rsp1_ready = 1'b0; observe();

        // Reset in BUSY cycle 8 of a req1 job while req0's result is still unread.
        d = rand128();
        do_job(0, 1'b0, d, eng_f(1'b0, d), 1'b0, wt);
        wt = -1;
        for (int k = 0; k < 40; k++) begin
            step(); drive_req(1, 1'b1, 1'b1, rand128()); observe();
            if (req1_ready) begin wt = k; break; end
        end
        check("mid_accept", 128'(wt >= 0), 128'(1));
        for (int k = 0; k < 8; k++) begin
            step(); drive_req(1, 1'b0, 1'b0, '0); observe();
        end
        step(); rst_n = 1'b0; #1;
        check("mid_rsp0_valid", 128'(rsp0_valid), 128'(0));
        check("mid_rsp1_valid", 128'(rsp1_valid), 128'(0));
        check("mid_rsp0_data", rsp0_data, '0);
        check("mid_eng_enable", 128'(eng_enable), 128'(0));
        check("mid_eng_start", 128'(eng_start), 128'(0));
        flush();
        repeat (2) @(posedge clk);
        #1; cyc++;
        rst_n = 1'b1; drive_req(0, 1'b1, 1'b0, {K, P}); observe();
        check("mid_init_ready", 128'(req0_ready), 128'(0));
        do_job(0, 1'b0, {K, P}, {K, C}, 1'b1, wt);
        check("mid_init_len", 128'(wt), 128'(0));

`ifdef DES_SCHED_TIMEOUT_EN
        hang = 1'b1;
        wt = -1;
        for (int k = 0; k < 40; k++) begin
            step(); drive_req(0, 1'b1, 1'b0, {K, P}); observe();
            if (req0_ready) break;
        end
        for (int k = 0; k < 60; k++) begin
            step(); drive_req(0, 1'b0, 1'b0, '0); observe();
            if (eng_abort) begin wt = cyc - last_acc; break; end
        end
        check("tmo_abort_at", 128'(wt), 128'(TMO + 1));
        step(); observe();
        check("tmo_rsp_valid", 128'(rsp0_valid), 128'(1));
        check("tmo_rsp_err", 128'(rsp0_err), 128'(1));
        check("tmo_rsp_data", rsp0_data, '0);
        hang = 1'b0;
        step(); rsp0_ready = 1'b1; observe();
        step(); rsp0_ready = 1'b0; observe();
        check("tmo_err_clear", 128'(rsp0_err), 128'(0));
        do_job(0, 1'b0, {K, P}, {K, C}, 1'b1, wt);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/des_job_scheduler.md
Name: des_job_scheduler

Overview:
- Shares one DES engine (16-round iterative, 128-bit in = {key[127:64], text[63:0]}) between two requesters with round-robin arbitration.
- Sequences the engine's start handshake and holds mode stable for the whole job.
- Buffers each result per requester so a stalled consumer never blocks the engine.
- Sits between the host/crypto front-end and the DES datapath instance.

Parameters:
- DATA_W, 128, job/result width ({key, text}).
- TIMEOUT_CYC, 24, BUSY-cycle limit before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  job 0 accepted this cycle
- req0_mode  in  1  0 encrypt, 1 decrypt
- req0_data  in  DATA_W  {key, text}
- rsp0_valid  out  1  result 0 available
- rsp0_ready  in  1  consumer 0 takes result
- rsp0_data  out  DATA_W  {key, result text}
- rsp0_err  out  1  result 0 is an abort (feature only)
- req1_*/rsp1_*  as above for requester 1
- eng_enable  out  1  engine clock enable, constant 1 out of reset
- eng_start  out  1  one-cycle start pulse
- eng_mode  out  1  mode, held ISSUE..BUSY
- eng_data_in  out  DATA_W  latched job
- eng_data_out  in  DATA_W  engine result, valid with eng_out_valid
- eng_out_valid  in  1  one-cycle result strobe
- eng_abort  out  1  one-cycle engine reset request (feature only)

Behaviour:
- Reset (async, rst_n=0): state=INIT; all rsp*_valid/err=0; rsp*_data=0; eng_start=0; eng_mode=0; eng_data_in=0; eng_abort=0; rr pointer=1, so requester 0 wins first; eng_enable=0 during reset.
- Interface is combinational-free from input to output, except that reqN_ready is decoded from state plus eligibility.
- FSM:
  - INIT: 1 cycle, covers the engine's post-reset start state; goes to IDLE.
  - IDLE: eligibleN = reqN_valid & !rspN_valid.
    - If any requester is eligible, grant it; if both are, grant the one not granted last.
    - reqN_ready=1 for exactly that cycle.
    - Latch owner, mode and data; go to ISSUE.
  - ISSUE: eng_start=1 with the latched data and mode; go to BUSY.
  - BUSY: eng_start=0, mode held.
    - On eng_out_valid: rsp[owner]_data <= eng_data_out, rsp[owner]_valid <= 1, rr pointer <= owner; go to IDLE.
- Latency: accept at cycle T, eng_start at T+1, eng_out_valid at T+16, rspN_valid high at T+17. Back-to-back jobs are accepted no earlier than T+17.
- Response: rspN_valid holds with stable data until rspN_ready. It clears the cycle after the handshake, and the requester becomes eligible again in that same cycle.
- Simultaneous events:
  - Capture and handshake can never hit the same buffer, because an owner is only granted when its buffer is empty.
  - A handshake on the other requester's buffer during BUSY is legal and independent.
- eng_out_valid outside BUSY is ignored.
- reqN_valid drop without ready is allowed; no job is taken.
- Reset mid-job: job lost, buffers cleared, restart from INIT.

Optional Feature:
- Macro: DES_SCHED_TIMEOUT_EN.
- With the macro:
  - An 8-bit BUSY cycle counter runs, cleared on entering BUSY.
  - If it reaches TIMEOUT_CYC without eng_out_valid: eng_abort=1 for one cycle, rsp[owner]_data=0, rsp[owner]_valid=1, rsp[owner]_err=1; go to INIT.
  - rspN_err clears with its valid handshake.
- Without the macro: no counter; eng_abort and rsp*_err tied 0; ports still present.

Decomposition:
- Package des_sched_pkg:
  - state enum {INIT, IDLE, ISSUE, BUSY}
  - MODE_ENCRYPT/MODE_DECRYPT
  - DES_ROUNDS=16
  - DES_LATENCY=16 (start to out_valid)
- One sub-module, des_rr_arbiter_2: 2-way round-robin grant from eligible vector plus last-owner bit.
- Response buffers are instantiated inline.

Test Plan:
- Single encrypt on req0: data={133457799BBCDFF1, 0123456789ABCDEF} -> rsp0_data={133457799BBCDFF1, 85E813540F0AB405} with rsp0_valid rising exactly 17 cycles after req0_ready.
- Decrypt round trip on req1: mode=1, data={133457799BBCDFF1, 85E813540F0AB405} -> rsp1_data text 0123456789ABCDEF.
- Both requesters valid continuously: grants alternate 0,1,0,1 and each gets 2 results over 4 jobs.
- rsp0_ready held 0 while both request: req0 is not re-granted; req1 keeps being served; after rsp0_ready pulses, req0 is granted next arbitration.
- Assert rst_n low at BUSY cycle 8: all valids 0 immediately; after release, INIT lasts 1 cycle, then a new job completes correctly.
- With DES_SCHED_TIMEOUT_EN and eng_out_valid forced 0: eng_abort pulses at BUSY cycle 24, rsp_err=1 with data 0; the next job succeeds.
